// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - single-clock FIFO with wrap-bit pointers, thresholds, flush and error flags
module sync_fifo_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int PTR_WIDTH = $clog2(DEPTH),
  parameter int AF_TH     = DEPTH - 2,
  parameter int AE_TH     = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               wr_en_i,
  input  logic [WIDTH-1:0]   wdata_i,
  input  logic               rd_en_i,
  input  logic               err_clr_i,
  output logic [WIDTH-1:0]   rdata_o,
  output logic [PTR_WIDTH:0] count_o,
  output logic               full_o,
  output logic               empty_o,
  output logic               almost_full_o,
  output logic               almost_empty_o,
  output logic               overflow_o,
  output logic               underflow_o,
  output logic               ovf_sticky_o,
  output logic               udf_sticky_o
);

  localparam logic [PTR_WIDTH:0] AF_C = (PTR_WIDTH + 1)'(AF_TH);
  localparam logic [PTR_WIDTH:0] AE_C = (PTR_WIDTH + 1)'(AE_TH);

  logic [WIDTH-1:0]   mem [DEPTH];

  logic [PTR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_WIDTH:0] count_q, count_d;
  logic [WIDTH-1:0]   rdata_q, rdata_d;
  logic               full_q, full_d;
  logic               empty_q, empty_d;
  logic               af_q, af_d;
  logic               ae_q, ae_d;
  logic               ovf_q, ovf_d;
  logic               udf_q, udf_d;
  logic               ovf_st_q, ovf_st_d;
  logic               udf_st_q, udf_st_d;

  logic               wr_acc;
  logic               rd_acc;

  // Accept decisions rely only on the registered flags from the start of the cycle.
  assign wr_acc = wr_en_i && !full_q && !flush_i;
  assign rd_acc = rd_en_i && !empty_q && !flush_i;

  // Next-state for pointers, read data, pulses and sticky flags; flags derive from next pointers.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    rdata_d  = rdata_q;
    ovf_d    = 1'b0;
    udf_d    = 1'b0;
    ovf_st_d = ovf_st_q;
    udf_st_d = udf_st_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        rdata_d  = mem[rd_ptr_q[PTR_WIDTH-1:0]];
      end
      ovf_d    = wr_en_i && full_q;
      udf_d    = rd_en_i && empty_q;
      // A new error in the same cycle as a clear leaves the flag set.
      ovf_st_d = ovf_d || (ovf_st_q && !err_clr_i);
      udf_st_d = udf_d || (udf_st_q && !err_clr_i);
    end
    count_d = wr_ptr_d - rd_ptr_d;
    empty_d = (wr_ptr_d == rd_ptr_d);
    full_d  = (wr_ptr_d[PTR_WIDTH-1:0] == rd_ptr_d[PTR_WIDTH-1:0]) &&
              (wr_ptr_d[PTR_WIDTH] != rd_ptr_d[PTR_WIDTH]);
    af_d    = (count_d >= AF_C);
    ae_d    = (count_d <= AE_C);
  end

  // Control and status registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= (AF_TH == 0);
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      ovf_st_q <= 1'b0;
      udf_st_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      ovf_st_q <= ovf_st_d;
      udf_st_q <= udf_st_d;
    end
  end

  // Storage array: never cleared, written only on accepted writes outside reset.
  always_ff @(posedge clk_i) begin
    if (rst_ni && wr_acc) begin
      mem[wr_ptr_q[PTR_WIDTH-1:0]] <= wdata_i;
    end
  end

  assign rdata_o        = rdata_q;
  assign count_o        = count_q;
  assign full_o         = full_q;
  assign empty_o        = empty_q;
  assign almost_full_o  = af_q;
  assign almost_empty_o = ae_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = udf_q;
  assign ovf_sticky_o   = ovf_st_q;
  assign udf_sticky_o   = udf_st_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - self-checking bench for sync_fifo_param against a queue model
module tb_sync_fifo_param;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int PW    = 3;
  localparam int AF_TH = 6;
  localparam int AE_TH = 2;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             wr_en;
  logic [WIDTH-1:0] wdata;
  logic             rd_en;
  logic             err_clr;
  logic [WIDTH-1:0] rdata;
  logic [PW:0]      count;
  logic             full, empty, afull, aempty, ovf, udf, ovf_st, udf_st;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] m_rdata;
  logic             m_ovf, m_udf, m_ovf_st, m_udf_st;

  sync_fifo_param #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_WIDTH(PW), .AF_TH(AF_TH), .AE_TH(AE_TH)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .wr_en_i(wr_en), .wdata_i(wdata),
    .rd_en_i(rd_en), .err_clr_i(err_clr), .rdata_o(rdata), .count_o(count),
    .full_o(full), .empty_o(empty), .almost_full_o(afull), .almost_empty_o(aempty),
    .overflow_o(ovf), .underflow_o(udf), .ovf_sticky_o(ovf_st), .udf_sticky_o(udf_st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: a queue holding the contents, rules applied at each edge.
  task automatic model_edge(input logic r, input logic f, input logic w,
                            input logic [WIDTH-1:0] d, input logic rd, input logic c);
    int n;
    n = mq.size();
    if (!r) begin
      mq.delete();
      m_rdata = '0; m_ovf = 0; m_udf = 0; m_ovf_st = 0; m_udf_st = 0;
    end else if (f) begin
      mq.delete();
      m_ovf = 0; m_udf = 0;
    end else begin
      m_ovf = w && (n == DEPTH);
      m_udf = rd && (n == 0);
      if (rd && n != 0) m_rdata = mq.pop_front();
      if (w && n != DEPTH) mq.push_back(d);
      m_ovf_st = m_ovf || (m_ovf_st && !c);
      m_udf_st = m_udf || (m_udf_st && !c);
    end
  endtask

  task automatic check_all();
    int n;
    n = mq.size();
    chk("count", 32'(count), 32'(n));
    chk("full", 32'(full), 32'(n == DEPTH));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("almost_full", 32'(afull), 32'(n >= AF_TH));
    chk("almost_empty", 32'(aempty), 32'(n <= AE_TH));
    chk("overflow", 32'(ovf), 32'(m_ovf));
    chk("underflow", 32'(udf), 32'(m_udf));
    chk("ovf_sticky", 32'(ovf_st), 32'(m_ovf_st));
    chk("udf_sticky", 32'(udf_st), 32'(m_udf_st));
    chk("rdata", 32'(rdata), 32'(m_rdata));
  endtask

  task automatic cyc(input logic r, input logic f, input logic w,
                     input logic [WIDTH-1:0] d, input logic rd, input logic c);
    rst_n = r; flush = f; wr_en = w; wdata = d; rd_en = rd; err_clr = c;
    @(posedge clk);
    model_edge(r, f, w, d, rd, c);
    #1;
    check_all();
  endtask

  task automatic wr(input logic [WIDTH-1:0] d);
    cyc(1, 0, 1, d, 0, 0);
  endtask

  task automatic rd();
    cyc(1, 0, 0, 8'h00, 1, 0);
  endtask

  task automatic idle();
    cyc(1, 0, 0, 8'h00, 0, 0);
  endtask

  initial begin
    rst_n = 0; flush = 0; wr_en = 0; wdata = 0; rd_en = 0; err_clr = 0;
    m_rdata = '0; m_ovf = 0; m_udf = 0; m_ovf_st = 0; m_udf_st = 0;

    // reset for two cycles
    cyc(0, 0, 0, 8'h00, 0, 0);
    cyc(0, 0, 0, 8'h00, 0, 0);
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_almost_full", 32'(afull), 32'd0);

    // fill 0x01..0x08
    for (int i = 1; i <= 8; i++) begin
      wr(8'(i));
      chk("fill_count", 32'(count), 32'(i));
    end
    chk("fill_full", 32'(full), 32'd1);

    // overflow: 0x55 is dropped
    wr(8'h55);
    chk("ovf_pulse", 32'(ovf), 32'd1);
    chk("ovf_count", 32'(count), 32'd8);
    idle();
    chk("ovf_one_cycle", 32'(ovf), 32'd0);

    // drain in order
    for (int i = 1; i <= 8; i++) begin
      rd();
      chk("drain_data", 32'(rdata), 32'(i));
    end

    // underflow keeps rdata
    rd();
    chk("udf_pulse", 32'(udf), 32'd1);
    chk("udf_rdata_held", 32'(rdata), 32'h08);
    cyc(1, 0, 0, 8'h00, 0, 1);
    chk("clr_ovf_sticky", 32'(ovf_st), 32'd0);
    chk("clr_udf_sticky", 32'(udf_st), 32'd0);

    // simultaneous rd+wr at full, empty, and mid
    for (int i = 0; i < 8; i++) wr(8'(8'hA0 + i));
    cyc(1, 0, 1, 8'hEE, 1, 0);
    chk("rdwr_full_count", 32'(count), 32'd7);
    chk("rdwr_full_ovf", 32'(ovf), 32'd1);
    for (int i = 0; i < 7; i++) rd();
    cyc(1, 0, 1, 8'hC3, 1, 0);
    chk("rdwr_empty_count", 32'(count), 32'd1);
    chk("rdwr_empty_udf", 32'(udf), 32'd1);
    for (int i = 0; i < 3; i++) wr(8'(8'hB0 + i));
    cyc(1, 0, 1, 8'hB3, 1, 0);
    chk("rdwr_mid_count", 32'(count), 32'd4);
    chk("rdwr_mid_data", 32'(rdata), 32'hC3);
    cyc(1, 0, 0, 8'h00, 0, 1);

    // wrap-around: 20 writes with 20 reads around count 4
    for (int i = 0; i < 20; i++) cyc(1, 0, 1, 8'(8'h10 + i), 1, 0);
    for (int i = 0; i < 4; i++) rd();
    chk("wrap_last", 32'(rdata), 32'h23);
    chk("wrap_no_ovf", 32'(ovf_st), 32'd0);
    chk("wrap_no_udf", 32'(udf_st), 32'd0);

    // flush at count 5 together with a write
    for (int i = 0; i < 5; i++) wr(8'(8'h60 + i));
    cyc(1, 1, 1, 8'h77, 0, 0);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    chk("flush_rdata", 32'(rdata), 32'h23);
    rd();
    chk("flush_nothing_stored", 32'(udf), 32'd1);
    cyc(1, 0, 0, 8'h00, 0, 1);

    // reset at count 5
    for (int i = 0; i < 5; i++) wr(8'(8'h80 + i));
    cyc(0, 0, 0, 8'h00, 0, 0);
    chk("rst_mid_count", 32'(count), 32'd0);
    chk("rst_mid_rdata", 32'(rdata), 32'd0);
    wr(8'h91);
    rd();
    chk("rst_mid_first", 32'(rdata), 32'h91);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      cyc(1, ($urandom_range(0, 39) == 0), 1'($urandom), 8'($urandom),
          1'($urandom), ($urandom_range(0, 15) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO with power-of-two depth, wrap-bit pointers, an occupancy count, programmable almost-full/almost-empty thresholds, a synchronous flush, and per-cycle overflow/underflow pulses with sticky error flags. It buffers data between a producer and a consumer in one clock domain. It also serves as the same-clock counterpart of the team's asynchronous FIFO.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 8, number of entries; power of two, ≥2
- PTR_WIDTH, $clog2(DEPTH), address width; pointers carry one extra wrap bit
- AF_TH, DEPTH-2, almost_full asserted when count ≥ AF_TH (1..DEPTH)
- AE_TH, 2, almost_empty asserted when count ≤ AE_TH (0..DEPTH-1)

- clk  in  1  single clock; all state updates on posedge
- rst  in  1  synchronous, active-low reset (0 at posedge resets)
- flush  in  1  synchronous clear of contents, active high
- wr_en  in  1  write request
- wdata  in  WIDTH  write data
- rd_en  in  1  read request
- err_clr  in  1  clears sticky error flags
- rdata  out  WIDTH  registered read data
- count  out  PTR_WIDTH+1  current occupancy, 0..DEPTH
- full, empty  out  1  occupancy flags, registered
- almost_full, almost_empty  out  1  threshold flags, registered
- overflow, underflow  out  1  one-cycle error pulses
- ovf_sticky, udf_sticky  out  1  latched error flags

## Operation
- Storage: mem[DEPTH] of WIDTH bits. Memory is not cleared on reset or flush.
- Pointers wr_ptr and rd_ptr are PTR_WIDTH+1 bits wide. The low PTR_WIDTH bits address mem. The MSB toggles on each wrap.
- count = wr_ptr − rd_ptr, computed modulo 2^(PTR_WIDTH+1).
- full: addresses equal, MSBs differ. empty: pointers fully equal.
- Write is accepted when wr_en=1 and full=0. Accepted write: mem[wr_ptr] ← wdata, then wr_ptr+1.
- Write attempted while full=1: no store, no pointer change, overflow=1 for that cycle.
- Read is accepted when rd_en=1 and empty=0. Accepted read: rdata ← mem[rd_ptr], then rd_ptr+1. rdata holds its value when no read is accepted.
- Read attempted while empty=1: rdata unchanged, underflow=1 for that cycle.
- Accept decisions use flags as they stand at the start of the cycle.
  - Full with wr_en and rd_en: read accepted, write rejected with overflow. Count becomes DEPTH−1.
  - Empty with wr_en and rd_en: write accepted, read rejected with underflow. Count becomes 1.
  - Neither full nor empty: both accepted, count unchanged.
- Sticky flags: ovf_sticky sets on any overflow pulse and udf_sticky on any underflow pulse. Both clear on err_clr=1. If a set and err_clr occur in the same cycle, set wins.
- Priority: rst > flush > rd/wr.
  - Flush clears both pointers and count, sets empty=1, full=0 and recomputes the almost flags.
  - Flush keeps rdata and the sticky flags unchanged, and generates no overflow/underflow pulses.
- All flags are registered from next-state count, so they are valid in the same cycle as count.

## Timing
- Reset values (rst=0 at posedge):
  - pointers=0, count=0, rdata=0
  - empty=1, full=0, almost_empty=1, almost_full=(AF_TH==0 ? 1 : 0)
  - overflow=0, underflow=0, ovf_sticky=0, udf_sticky=0
- Reset mid-operation discards all contents. The first cycle after rst=1 behaves as an empty FIFO.
- Write-to-read latency:
  - Data written at edge N updates empty at edge N, so the flag is visible after N.
  - rd_en sampled at edge N+1 returns that data on rdata after edge N+1.
- Read latency is 1 cycle: rdata is valid the cycle after the rd_en edge.
- The count and flags reflect all accepted operations of the previous edge, with no additional lag.
- overflow/underflow are high for exactly the cycle following the offending request edge.
- Wrap-around is seamless: at address DEPTH−1 the pointer rolls to 0 and the MSB toggles. No bubble occurs.

## Test plan
All scenarios use WIDTH=8, DEPTH=8, AF_TH=6, AE_TH=2.
- Reset/fill/drain: hold rst=0 for 2 cycles, then write 0x01..0x08 on consecutive cycles.
  - count steps 1..8. almost_empty drops at count=3, almost_full rises at count=6, full=1 at count 8.
  - Read 8 times: rdata = 0x01..0x08 in order. empty=1 at the end.
- Overflow/underflow:
  - Write 0x55 with full=1: overflow pulses 1 cycle, ovf_sticky=1, count stays 8. 0x55 is never read back.
  - Read with empty=1: underflow pulses, rdata unchanged, udf_sticky=1.
  - err_clr=1 clears both sticky flags.
- Simultaneous rd+wr:
  - At count=8: rd accepted, wr rejected with overflow, count=7.
  - At count=0: wr accepted, rd rejected with underflow, count=1.
  - At count=4: count stays 4 and data order is preserved.
- Wrap-around: run 20 writes interleaved with 20 reads at count ≈4, using data 0x10..0x23. All 20 values are read back in order with no overflow or underflow.
- Flush/reset mid-stream:
  - At count=5, flush=1 together with wr_en=1: count=0, empty=1, no write stored, rdata retained.
  - Separately, rst=0 at count=5: all outputs take their reset values on the next cycle.
